// File: rtl/paula_intctl.sv
// Paula interrupt controller: INTENA/INTREQ registers, source latching, priority encode to _ipl.
// _ipl registered, two enabled cycles after a source pulse; no backpressure. Optional `PAULA_INT_NMI_EN adds level-7 nmi.
module paula_intctl (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [7:0]  reg_address_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        ciaa_irq,
    input  logic        ciab_irq,
    input  logic        ser_tbe,
    input  logic        dsk_blk,
    input  logic        copper,
    input  logic        vbl,
    input  logic        blit,
    input  logic [3:0]  audio,
    input  logic        rbf,
    input  logic        dsk_syn,
`ifdef PAULA_INT_NMI_EN
    input  logic        nmi,
`endif
    output logic [2:0]  _ipl,
    output logic [3:0]  audio_req
);

    localparam logic [7:0] ADDR_INTENAR = 8'h0E;
    localparam logic [7:0] ADDR_INTREQR = 8'h0F;
    localparam logic [7:0] ADDR_INTENA  = 8'h4D;
    localparam logic [7:0] ADDR_INTREQ  = 8'h4E;

    logic [14:0] intena_q, intena_d;
    logic [14:0] intreq_q, intreq_d;
    logic [2:0]  ipl_q, ipl_d;
    logic [14:0] hw_set;
    logic [14:0] pending;
    logic [2:0]  level;
    logic        wr_intena, wr_intreq;

    assign wr_intena = (reg_address_in == ADDR_INTENA);
    assign wr_intreq = (reg_address_in == ADDR_INTREQ);

    // Bits 2 (SOFT) and 14 have no hardware source.
    assign hw_set = {1'b0, ciab_irq, dsk_syn, rbf, audio, blit, vbl, copper,
                     ciaa_irq, 1'b0, dsk_blk, ser_tbe};

    always_comb begin
        intena_d = intena_q;
        if (wr_intena) begin
            if (data_in[15])
                intena_d = intena_q | data_in[14:0];
            else
                intena_d = intena_q & ~data_in[14:0];
        end
    end

    // Hardware set is OR'd after the CPU update so it wins over a same-cycle clear.
    always_comb begin
        intreq_d = intreq_q;
        if (wr_intreq) begin
            if (data_in[15])
                intreq_d = intreq_q | data_in[14:0];
            else
                intreq_d = intreq_q & ~data_in[14:0];
        end
        intreq_d = intreq_d | hw_set;
    end

    assign pending = intreq_q & intena_q;

    always_comb begin
        level = 3'd0;
        if (intena_q[14]) begin
            if (pending[14] || pending[13])
                level = 3'd6;
            else if (|pending[12:11])
                level = 3'd5;
            else if (|pending[10:7])
                level = 3'd4;
            else if (|pending[6:4])
                level = 3'd3;
            else if (pending[3])
                level = 3'd2;
            else if (|pending[2:0])
                level = 3'd1;
        end
    end

`ifdef PAULA_INT_NMI_EN
    logic nmi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            nmi_q <= 1'b0;
        else if (clk7_en)
            nmi_q <= nmi;
    end

    assign ipl_d = nmi_q ? 3'b000 : ~level;
`else
    assign ipl_d = ~level;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            intena_q <= '0;
            intreq_q <= '0;
            ipl_q    <= 3'b111;
        end else if (clk7_en) begin
            intena_q <= intena_d;
            intreq_q <= intreq_d;
            ipl_q    <= ipl_d;
        end
    end

    always_comb begin
        data_out = 16'h0000;
        if (reg_address_in == ADDR_INTENAR)
            data_out = {1'b0, intena_q};
        else if (reg_address_in == ADDR_INTREQR)
            data_out = {1'b0, intreq_q};
    end

    assign _ipl      = ipl_q;
    assign audio_req = intreq_q[10:7];

endmodule

// File: tb/tb_paula_intctl.sv
// Bench for paula_intctl: vector table plus hand sequences; _ipl checked through a due-cycle scoreboard.
module tb_paula_intctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic [7:0]  reg_address_in;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        ciaa_irq, ciab_irq;
    logic        ser_tbe, dsk_blk, copper, vbl, blit, rbf, dsk_syn;
    logic [3:0]  audio;
    logic [2:0]  ipl;
    logic [3:0]  audio_req;
`ifdef PAULA_INT_NMI_EN
    logic        nmi;
`endif

    paula_intctl dut (
        .clk(clk),
        .reset(reset),
        .clk7_en(clk7_en),
        .reg_address_in(reg_address_in),
        .data_in(data_in),
        .data_out(data_out),
        .ciaa_irq(ciaa_irq),
        .ciab_irq(ciab_irq),
        .ser_tbe(ser_tbe),
        .dsk_blk(dsk_blk),
        .copper(copper),
        .vbl(vbl),
        .blit(blit),
        .audio(audio),
        .rbf(rbf),
        .dsk_syn(dsk_syn),
`ifdef PAULA_INT_NMI_EN
        .nmi(nmi),
`endif
        ._ipl(ipl),
        .audio_req(audio_req)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] A_ENAR = 8'h0E;
    localparam logic [7:0] A_REQR = 8'h0F;
    localparam logic [7:0] A_ENA  = 8'h4D;
    localparam logic [7:0] A_REQ  = 8'h4E;
    localparam logic [7:0] A_IDLE = 8'h00;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] pulses;
        logic        ciaa;
        logic        ciab;
        logic [15:0] exp_req;
        logic [15:0] exp_ena;
        logic [2:0]  exp_ipl;
    } vec_t;

    typedef struct {
        int         due;
        logic [2:0] ipl;
        int         id;
    } sb_t;

    vec_t vt[20];
    sb_t  sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ecnt  = 0;
    int   sbid  = 0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(posedge clk)
        if (clk7_en && !reset) ecnt <= ecnt + 1;

    // _ipl expectations come due a fixed number of enabled edges after they were driven.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == ecnt) begin
            sb_t e;
            e = sb.pop_front();
            chk($sformatf("ipl_sb%0d", e.id), {13'd0, ipl}, {13'd0, e.ipl});
        end
    end

    task automatic drive_pulses(input logic [15:0] p);
        ser_tbe = p[0];
        dsk_blk = p[1];
        copper  = p[4];
        vbl     = p[5];
        blit    = p[6];
        audio   = p[10:7];
        rbf     = p[11];
        dsk_syn = p[12];
    endtask

    task automatic step(input logic [7:0] a, input logic [15:0] d, input logic [15:0] p,
                        input logic [2:0] exp_ipl);
        sb_t t;
        reg_address_in = a;
        data_in        = d;
        drive_pulses(p);
        t.due = ecnt + 2;
        t.ipl = exp_ipl;
        t.id  = sbid;
        sbid++;
        sb.push_back(t);
        @(posedge clk);
        #1;
        drive_pulses(16'h0000);
        reg_address_in = A_IDLE;
        data_in        = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string nm);
        reg_address_in = a;
        #1;
        chk(nm, data_out, exp);
        reg_address_in = A_IDLE;
    endtask

    initial begin
        reset = 1'b1;
        clk7_en = 1'b1;
        reg_address_in = A_IDLE;
        data_in = 16'h0000;
        ciaa_irq = 1'b0;
        ciab_irq = 1'b0;
        drive_pulses(16'h0000);
`ifdef PAULA_INT_NMI_EN
        nmi = 1'b0;
`endif

        // Vectors run in order from the reset state.
        vt[0]  = '{A_ENA,  16'hC008, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h4008, 3'b111};
        vt[1]  = '{A_IDLE, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0008, 16'h4008, 3'b101};
        vt[2]  = '{A_REQ,  16'h0008, 16'h0000, 1'b1, 1'b0, 16'h0008, 16'h4008, 3'b101};
        vt[3]  = '{A_REQ,  16'h0008, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h4008, 3'b111};
        vt[4]  = '{A_ENA,  16'hE028, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h6028, 3'b111};
        vt[5]  = '{A_IDLE, 16'h0000, 16'h0020, 1'b0, 1'b0, 16'h0020, 16'h6028, 3'b100};
        vt[6]  = '{A_IDLE, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h2020, 16'h6028, 3'b001};
        vt[7]  = '{A_ENA,  16'h4000, 16'h0000, 1'b0, 1'b0, 16'h2020, 16'h2028, 3'b111};
        vt[8]  = '{A_REQ,  16'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h2028, 3'b111};
        vt[9]  = '{A_ENA,  16'hC004, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h602C, 3'b111};
        vt[10] = '{A_REQ,  16'h8004, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h602C, 3'b110};
        vt[11] = '{8'h4F,  16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h602C, 3'b110};
        vt[12] = '{A_ENA,  16'h9FF3, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h7FFF, 3'b110};
        vt[13] = '{A_IDLE, 16'h0000, 16'h0210, 1'b0, 1'b0, 16'h0214, 16'h7FFF, 3'b011};
        vt[14] = '{A_IDLE, 16'h0000, 16'h1801, 1'b0, 1'b0, 16'h1A15, 16'h7FFF, 3'b010};
        vt[15] = '{A_REQ,  16'hC000, 16'h0000, 1'b0, 1'b0, 16'h5A15, 16'h7FFF, 3'b001};
        vt[16] = '{A_REQ,  16'h0002, 16'h0002, 1'b0, 1'b0, 16'h5A17, 16'h7FFF, 3'b001};
        vt[17] = '{A_REQ,  16'h7FFF, 16'h0040, 1'b0, 1'b0, 16'h0040, 16'h7FFF, 3'b100};
        vt[18] = '{A_IDLE, 16'h0000, 16'h0780, 1'b0, 1'b0, 16'h07C0, 16'h7FFF, 3'b011};
        vt[19] = '{A_REQ,  16'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h7FFF, 3'b111};

        #2;
        chk("rst_ipl", {13'd0, ipl}, 16'h0007);
        rd(A_ENAR, 16'h0000, "rst_intena");
        rd(A_REQR, 16'h0000, "rst_intreq");
        #6;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Build intreq=0x2008 with _ipl=101, then reset asynchronously mid-cycle.
        step(A_ENA, 16'hC008, 16'h0000, 3'b111);
        ciaa_irq = 1'b1;
        ciab_irq = 1'b1;
        step(A_IDLE, 16'h0000, 16'h0000, 3'b101);
        idle(1);
        rd(A_REQR, 16'h2008, "pre_rst_intreq");
        @(negedge clk);
        #1;
        ciaa_irq = 1'b0;
        ciab_irq = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_ipl", {13'd0, ipl}, 16'h0007);
        rd(A_ENAR, 16'h0000, "mid_rst_intena");
        rd(A_REQR, 16'h0000, "mid_rst_intreq");
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            ciaa_irq = vt[i].ciaa;
            ciab_irq = vt[i].ciab;
            step(vt[i].addr, vt[i].data, vt[i].pulses, vt[i].exp_ipl);
            rd(A_REQR, vt[i].exp_req, $sformatf("v%0d_intreq", i));
            rd(A_ENAR, vt[i].exp_ena, $sformatf("v%0d_intena", i));
            chk($sformatf("v%0d_audio_req", i), {12'd0, audio_req}, {12'd0, vt[i].exp_req[10:7]});
        end
        ciaa_irq = 1'b0;
        ciab_irq = 1'b0;
        idle(2);
        rd(8'h4F, 16'h0000, "unsel_read");

        // Disabled cycle: write and pulse must both be ignored.
        clk7_en = 1'b0;
        reg_address_in = A_REQ;
        data_in = 16'h8001;
        vbl = 1'b1;
        @(posedge clk);
        #1;
        vbl = 1'b0;
        data_in = 16'h0000;
        clk7_en = 1'b1;
        rd(A_REQR, 16'h0000, "en_low_intreq");
        idle(2);
        chk("en_low_ipl", {13'd0, ipl}, 16'h0007);

        // Pulse latency: still idle one edge after the pulse, asserted the edge after.
        step(A_IDLE, 16'h0000, 16'h0020, 3'b100);
        chk("lat_n1", {13'd0, ipl}, 16'h0007);
        idle(1);
        step(A_REQ, 16'h0020, 16'h0000, 3'b111);
        chk("clr_lat_n1", {13'd0, ipl}, 16'h0004);
        idle(2);

`ifdef PAULA_INT_NMI_EN
        step(A_ENA, 16'h7FFF, 16'h0000, 3'b111);
        nmi = 1'b1;
        step(A_IDLE, 16'h0000, 16'h0000, 3'b000);
        chk("nmi_n1", {13'd0, ipl}, 16'h0007);
        idle(1);
        nmi = 1'b0;
        step(A_IDLE, 16'h0000, 16'h0000, 3'b000);
        step(A_IDLE, 16'h0000, 16'h0000, 3'b111);
        idle(2);
`endif

        idle(3);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: %0d ipl expectations never came due, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/paula_intctl.md
Name: paula_intctl

Overview:
- Paula-side interrupt controller; the receiving end of the CIA irq lines and of every other chip interrupt source.
- Holds the INTENA and INTREQ registers, latches the level and pulse sources into INTREQ, and priority-encodes the enabled pending requests.
- Drives the registered 68000 interrupt priority level (_ipl).
- Sits on the chip-register bus beside the other Paula blocks.

Parameters:
- none (register addresses fixed: INTENAR 0x01C, INTREQR 0x01E, INTENA 0x09A, INTREQ 0x09C; byte address, reg_address_in = addr[8:1])

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk7_en  in  1  7 MHz clock enable; all state updates only on enabled cycles
- reg_address_in  in  8  chip register address bits [8:1]
- data_in  in  16  chip bus write data
- data_out  out  16  chip bus read data; 0 when not selected
- ciaa_irq  in  1  CIA-A irq, level (INTREQ bit 3 PORTS)
- ciab_irq  in  1  CIA-B irq, level (INTREQ bit 13 EXTER)
- ser_tbe  in  1  pulse, bit 0
- dsk_blk  in  1  pulse, bit 1
- copper  in  1  pulse, bit 4
- vbl  in  1  pulse, bit 5
- blit  in  1  pulse, bit 6
- audio  in  4  pulses, bits 10:7
- rbf  in  1  pulse, bit 11
- dsk_syn  in  1  pulse, bit 12
- _ipl  out  3  active-low interrupt priority level to CPU
- audio_req  out  4  INTREQ[10:7] copy, for the audio DMA state machines

Behaviour:
- Reset (async): intena = 0, intreq = 0, _ipl = 3'b111, data_out = 0.
- Reads (combinational, no side effects):
  - address 0x01C → {1'b0, intena[14:0]}
  - address 0x01E → {1'b0, intreq[14:0]}
  - any other address → 0
- INTENA write (address 0x09A, enabled cycle):
  - data_in[15]=1: intena |= data_in[14:0]
  - data_in[15]=0: intena &= ~data_in[14:0]
  - Bit 14 is the master enable.
- INTREQ write (address 0x09C): same SET/CLR rule, applied to intreq.
- Hardware set, every enabled cycle: intreq[i] |= source_i for all sources.
  - ciaa_irq and ciab_irq are levels. A CPU clear while the CIA irq is still high is overridden in the same cycle, so the bit reappears until the CIA ICR is read.
- Simultaneous CPU clear and hardware set of the same bit: the set wins.
- Bit 2 (SOFT) and bit 14 are set only by CPU write.
- Priority, on pending = intreq & intena, gated by intena[14]:
  - bit 14 → level 6
  - bit 13 → 6
  - bits 12:11 → 5
  - bits 10:7 → 4
  - bits 6:4 → 3
  - bit 3 → 2
  - bits 2:0 → 1
  - none pending → 0
  - Highest level wins.
- _ipl = ~level, registered on clk7_en.
  - Latency: a source pulse at enabled cycle N → intreq set at N+1 → _ipl valid at N+2.
  - A clear at N → _ipl deasserts at N+2.
- intena[14]=0 forces level 0 regardless of pending bits; intreq still latches.
- clk7_en low: all registers hold, sources ignored. Pulses must be aligned to an enabled cycle.
- audio_req = intreq[10:7], unregistered beyond intreq.

Optional Feature:
- Macro: PAULA_INT_NMI_EN
- When defined:
  - Adds input port nmi (1 bit, level).
  - While nmi=1, the encoded level is 7 (_ipl = 3'b000), overriding intena[14] and all pending bits.
  - Same registered 2-cycle latency.
- When undefined: the port is absent and the maximum level is 6.

Test Plan:
- Reset asserted mid-operation with intreq=0x2008, _ipl=3'b101 → immediately intreq=0, intena=0, _ipl=3'b111; reads of 0x01C/0x01E return 0x0000.
- Write INTENA 0xC008, pulse ciaa_irq high → INTREQR reads 0x0008; _ipl=3'b101 two enabled cycles after assertion.
- ciaa_irq held high, write INTREQ 0x0008 (clear) → bit stays set and _ipl stays 3'b101; drop ciaa_irq, clear again → INTREQR 0x0000, _ipl 3'b111 two cycles later.
- INTENA 0xE028, pulse vbl, then assert ciab_irq → _ipl goes 3'b100 (level 3), then 3'b001 (level 6); write INTENA 0x4000 → _ipl 3'b111 with INTREQR still 0x2020.
- Write INTREQ 0x8004 (SOFT) with INTENA 0xC004 → _ipl 3'b110; a write to an unrelated address 0x09E leaves intreq and intena unchanged.
- With PAULA_INT_NMI_EN: intena=0, nmi=1 → _ipl 3'b000 after 2 enabled cycles; release nmi → 3'b111.
